// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
// ---------------
// Handshaked pipeline stage register with a two-entry skid buffer. It carries one
// control bundle and one data bundle between two pipeline stages using valid/ready.
// in_ready is driven straight from a flop, so there is no combinational path from
// out_ready or in_valid to in_ready, and throughput is one entry per cycle.
//
// Storage:
//   main register - the head entry; drives out_ctrl/out_data
//   skid register - catches the entry accepted while the head is stalled
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   flush      in   drop all held entries and any entry offered this cycle
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage can accept (registered)
//   in_ctrl    in   upstream control bundle  [CTRL_W]
//   in_data    in   upstream data bundle     [DATA_W]
//   out_valid  out  out_ctrl/out_data hold a valid entry
//   out_ready  in   downstream accepts
//   out_ctrl   out  head control; CTRL_BUBBLE when out_valid=0 [CTRL_W]
//   out_data   out  head data; don't-care when out_valid=0      [DATA_W]
//   occupancy  out  number of held entries, 0..2

module pipe_skid_stage #(
    parameter int unsigned          CTRL_W      = 12,
    parameter int unsigned          DATA_W      = 128,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,

    output logic [1:0]        occupancy
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                out_valid_q;
    logic                in_ready_q;

    logic                push;
    logic                pop;

    // Handshakes use only the registered flags, never the combinational state.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Next-state and next-payload selection.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d     = StOne;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end

            StOne: begin
                if (push && pop) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (push) begin
                    // Head is stalled: park the new entry behind it.
                    state_d     = StFull;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (pop) begin
                    // Going empty: main_ctrl becomes the bubble so out_ctrl is a
                    // clean flop output with no stale control leaking through.
                    state_d     = StEmpty;
                    main_ctrl_d = CTRL_BUBBLE;
                end
            end

            StFull: begin
                // in_ready is low here, so push cannot happen.
                if (pop) begin
                    state_d     = StOne;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end

            default: begin
                state_d     = StEmpty;
                main_ctrl_d = CTRL_BUBBLE;
            end
        endcase

        // Flush overrides any handshake; a same-cycle push is dropped and a
        // same-cycle pop has already been taken by downstream.
        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = CTRL_BUBBLE;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
        end
    end

    // Single state register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= (state_d != StEmpty);
            in_ready_q  <= (state_d != StFull);
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, handshaked pipeline stage register; next generation of the fixed-field ID/EX latch.
- Carries one control bundle and one data bundle of configurable width between two pipeline stages using valid/ready.
- A 2-entry skid buffer gives a fully registered in_ready with no throughput loss.
- flush kills in-flight contents; the output presents a configurable bubble control word whenever no valid entry exists.

Parameters:
CTRL_W, 12, width of control bundle (RegDst/ALUSrc/MemRead/MemWrite/MemtoReg/RegWrite/ALUop/... packed)
DATA_W, 128, width of data bundle (operands, immediate, register ids, funct, shamt packed)
CTRL_BUBBLE, {CTRL_W{1'b0}}, control word driven when out_valid=0 (no register/memory write side effects)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all held entries and any entry offered this cycle
in_valid  input  1  upstream has an entry
in_ready  output  1  stage can accept; registered (depends on state only)
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  out_ctrl/out_data hold a valid entry
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_W  head-entry control; CTRL_BUBBLE when out_valid=0
out_data  output  DATA_W  head-entry data; don't-care when out_valid=0
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Reset: sync, active-high; clock clk. Result: state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid register=0.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A transfer occurs only on a rising edge with both signals high.
  - in_ready must not combinationally depend on out_ready or in_valid.
- Storage: main register (drives outputs) plus skid register.
- States (occupancy encoding):
  - EMPTY(0): push -> ONE, main<=in. No push -> stay.
  - ONE(1):
    - push & pop -> ONE, main<=in.
    - push & !pop -> FULL, skid<=in, main held.
    - !push & pop -> EMPTY.
    - Neither -> hold.
  - FULL(2): in_ready=0, so push is impossible.
    - pop -> ONE, main<=skid.
    - No pop -> hold.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
- Latency: 1 cycle from push into EMPTY to out_valid. Throughput is 1 entry/cycle when out_ready is held high.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush or rst.
- out_ctrl while EMPTY: forced to CTRL_BUBBLE, registered, never glitching from stale main contents.
- Output stability: while out_valid=1 and out_ready=0, out_ctrl and out_data are held stable.
- Flush:
  - Priority: rst > flush > handshake.
  - Next state is EMPTY, out_ctrl<=CTRL_BUBBLE, occupancy<=0.
  - An input pushed in the same cycle is dropped.
  - A pop in the same cycle counts as completed downstream; the stage takes no further action.
- Reset mid-operation: identical to flush plus out_data<=0.
- Simultaneous flush & rst: reset values.
- Widths: no arithmetic on payload. occupancy is a 2-bit saturating state encoding, never 3.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=CTRL_BUBBLE every cycle.
- Streaming: out_ready=1, push ctrl=0x001..0x008 with data=i*0x11 on 8 consecutive cycles -> each appears 1 cycle later in order; in_ready stays 1; occupancy stays 1.
- Backpressure/skid: push A=0x0A5, B=0x05A with out_ready=0 -> after B occupancy=2, in_ready=0, out_ctrl=0x0A5 held. Raise out_ready -> A popped, next cycle out_ctrl=0x05A, in_ready=1.
- Full with in_valid held: FULL with in_valid=1 and C=0x0C3 offered for 3 cycles -> C not accepted until in_ready=1; C emerges after B with no duplication.
- Flush while FULL with simultaneous push: occupancy=2, flush=1, in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=CTRL_BUBBLE; pushed entry never appears.
- Reset mid-stream: rst during ONE with out_ready=0 -> next cycle all outputs at reset values; the first push after release gives out_valid 1 cycle later.
